// File: rtl/gate_trainer_seq.sv
// Run-time selectable bitwise gate trainer with an automatic truth-table sweep.
// Each operand combination is held for HOLD_CYCLES cycles so it can be read on LEDs.
module gate_trainer_seq #(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] a_cur,
  output logic [WIDTH-1:0] b_cur,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   comb_q, comb_d, comb_inc;
  logic [HW-1:0]        hold_q, hold_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     a_cur_q, a_cur_d;
  logic [WIDTH-1:0]     b_cur_q, b_cur_d;
  logic                 valid_q, valid_d;
  logic                 hold_last, comb_last;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  assign hold_last = (hold_q == HOLD_LAST);
  assign comb_last = &comb_q;
  assign comb_inc  = comb_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      comb_q   <= '0;
      hold_q   <= '0;
      result_q <= '0;
      a_cur_q  <= '0;
      b_cur_q  <= '0;
      valid_q  <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      comb_q   <= comb_d;
      hold_q   <= hold_d;
      result_q <= result_d;
      a_cur_q  <= a_cur_d;
      b_cur_q  <= b_cur_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mode && start) state_d = SWEEP;
      SWEEP: begin
        if (!mode)                       state_d = IDLE;
        else if (hold_last && comb_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state; a combination advance updates a_cur/b_cur while result
  // still shows the old pair, hence valid is cleared for that one cycle.
  always_comb begin
    comb_d   = comb_q;
    hold_d   = hold_q;
    result_d = result_q;
    a_cur_d  = a_cur_q;
    b_cur_d  = b_cur_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          a_cur_d  = a_in;
          b_cur_d  = b_in;
          result_d = apply_op(op, a_in, b_in);
          valid_d  = 1'b1;
        end else if (start) begin
          comb_d   = '0;
          hold_d   = '0;
          a_cur_d  = '0;
          b_cur_d  = '0;
          result_d = apply_op(op, '0, '0);
          valid_d  = 1'b1;
        end else begin
          valid_d  = 1'b0;
        end
      end
      SWEEP: begin
        if (!mode) begin
          valid_d = 1'b0;
        end else begin
          result_d = apply_op(op, a_cur_q, b_cur_q);
          if (hold_last) begin
            hold_d = '0;
            if (comb_last) begin
              valid_d = 1'b1;
            end else begin
              comb_d  = comb_inc;
              a_cur_d = comb_inc[2*WIDTH-1:WIDTH];
              b_cur_d = comb_inc[WIDTH-1:0];
              valid_d = 1'b0;
            end
          end else begin
            hold_d  = hold_q + 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == SWEEP);
    done = (state_q == DONE);
  end

  assign result = result_q;
  assign a_cur  = a_cur_q;
  assign b_cur  = b_cur_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_gate_trainer_seq.sv
// Directed bench for gate_trainer_seq: manual ops, sweep, abort, ena freeze,
// async reset and a WIDTH=1/HOLD_CYCLES=1 instance.
module tb_gate_trainer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       ena2 = 1'b1, mode2 = 1'b0, start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [2:0] op2 = '0;
  logic [1:0] res2, ac2, bc2;
  logic       v2, busy2, done2;

  logic       ena1 = 1'b1, mode1 = 1'b0, start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [2:0] op1 = '0;
  logic [0:0] res1, ac1, bc1;
  logic       v1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_trainer_seq #(.WIDTH(2), .HOLD_CYCLES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .a_in(a2), .b_in(b2), .op(op2),
    .mode(mode2), .start(start2), .result(res2), .a_cur(ac2), .b_cur(bc2),
    .valid(v2), .busy(busy2), .done(done2)
  );

  gate_trainer_seq #(.WIDTH(1), .HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .a_in(a1), .b_in(b1), .op(op1),
    .mode(mode1), .start(start1), .result(res1), .a_cur(ac1), .b_cur(bc1),
    .valid(v1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] man_exp [8];
    int k, ea, eb, n;
    man_exp = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10};

    // Reset values
    #2;
    chk("rst_result", res2, 0);
    chk("rst_a_cur", ac2, 0);
    chk("rst_b_cur", bc2, 0);
    chk("rst_valid", v2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual mode, a=10 b=11, op 0..7
    mode2 = 1'b0; a2 = 2'b10; b2 = 2'b11;
    for (int i = 0; i < 8; i++) begin
      op2 = 3'(i);
      tick();
      chk($sformatf("man_res_op%0d", i), res2, man_exp[i]);
      chk($sformatf("man_valid_op%0d", i), v2, 1);
    end
    chk("man_a_cur", ac2, 2);
    chk("man_b_cur", bc2, 3);

    // Sweep mode idle without start
    op2 = 3'd5; mode2 = 1'b1; start2 = 1'b0;
    tick();
    chk("idle_valid", v2, 0);
    chk("idle_res_hold", res2, 2);
    chk("idle_busy", busy2, 0);

    // XOR sweep, 16 combos x 4 cycles
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("sw0_busy", busy2, 1);
    chk("sw0_a", ac2, 0);
    chk("sw0_b", bc2, 0);
    chk("sw0_valid", v2, 1);
    chk("sw0_res", res2, 0);
    for (int c = 1; c <= 63; c++) begin
      tick();
      k = c / 4; ea = k >> 2; eb = k & 3;
      chk($sformatf("sw%0d_a", c), ac2, ea);
      chk($sformatf("sw%0d_b", c), bc2, eb);
      chk($sformatf("sw%0d_valid", c), v2, (c % 4) != 0);
      if ((c % 4) != 0) chk($sformatf("sw%0d_res", c), res2, ea ^ eb);
      chk($sformatf("sw%0d_busy", c), busy2, 1);
      chk($sformatf("sw%0d_done", c), done2, 0);
    end
    tick();
    chk("sw64_done", done2, 1);
    chk("sw64_busy", busy2, 0);
    chk("sw64_a", ac2, 3);
    chk("sw64_b", bc2, 3);
    chk("sw64_res", res2, 0);
    tick();
    chk("sw65_done", done2, 0);
    chk("sw65_busy", busy2, 0);

    // Abort at combination 5
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (20) tick();
    chk("ab_a", ac2, 1);
    chk("ab_b", bc2, 1);
    mode2 = 1'b0; a2 = 2'b01; b2 = 2'b10; op2 = 3'd1;
    tick();
    chk("ab_busy", busy2, 0);
    chk("ab_done", done2, 0);
    chk("ab_valid", v2, 0);
    chk("ab_a_hold", ac2, 1);
    tick();
    chk("ab_man_res", res2, 3);
    chk("ab_man_valid", v2, 1);
    chk("ab_man_a", ac2, 1);
    chk("ab_man_b", bc2, 2);
    chk("ab_man_done", done2, 0);

    // ena freeze for 10 cycles mid-hold
    mode2 = 1'b1; op2 = 3'd5; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("en_busy", busy2, 1);
    n = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
      if (n == 6) ena2 = 1'b0;
      if (n == 16) begin
        chk("en_frz_a", ac2, 0);
        chk("en_frz_b", bc2, 1);
        chk("en_frz_res", res2, 1);
        chk("en_frz_valid", v2, 1);
        chk("en_frz_busy", busy2, 1);
        ena2 = 1'b1;
      end
    end
    chk("en_len", n, 74);
    tick();

    // Async reset mid-sweep
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (10) tick();
    chk("ar_pre_b", bc2, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_b", bc2, 0);
    chk("ar_res", res2, 0);
    chk("ar_busy", busy2, 0);
    chk("ar_valid", v2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("ar_re_busy", busy2, 1);
    chk("ar_re_b", bc2, 0);
    repeat (4) tick();
    chk("ar_re4_a", ac2, 0);
    chk("ar_re4_b", bc2, 1);

    // WIDTH=1, HOLD_CYCLES=1, NAND, start held high
    op1 = 3'd3; mode1 = 1'b1; start1 = 1'b1;
    tick();
    chk("w1_e0_res", res1, 1);
    chk("w1_e0_busy", busy1, 1);
    chk("w1_e0_valid", v1, 1);
    tick();
    chk("w1_e1_ab", {ac1, bc1}, 2'b01);
    chk("w1_e1_res", res1, 1);
    chk("w1_e1_valid", v1, 0);
    tick();
    chk("w1_e2_ab", {ac1, bc1}, 2'b10);
    chk("w1_e2_res", res1, 1);
    tick();
    chk("w1_e3_ab", {ac1, bc1}, 2'b11);
    chk("w1_e3_done", done1, 0);
    tick();
    chk("w1_e4_done", done1, 1);
    chk("w1_e4_busy", busy1, 0);
    chk("w1_e4_res", res1, 0);
    tick();
    chk("w1_e5_done", done1, 0);
    chk("w1_e5_busy", busy1, 0);
    tick();
    chk("w1_e6_busy", busy1, 1);
    chk("w1_e6_ab", {ac1, bc1}, 2'b00);
    chk("w1_e6_res", res1, 1);
    start1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
